alu_issue_stage: RTL and testbench

Operand-issue stage directly upstream of the 32-bit combinational ALU. It accepts ALU commands (operands, function code, tag) over a valid/ready handshake and buffers them in a small FIFO. It drives one command at a time onto the ALU inputs from registers, then captures the ALU result into a held output register. The result is presented downstream with its tag and an error flag under a second valid/ready handshake.

---
 rtl/alu_issue_stage.sv | 144 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : FIFO-buffered operand issue into a combinational ALU, with a
//            registered, handshaked result holding register.
// Revision : 1.0
// ============================================================================
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic [2:0]                 in_f,
  input  logic [TAG_W-1:0]           in_tag,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  output logic [2:0]                 alu_f,
  input  logic [31:0]                alu_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_y,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;

  logic [31:0]      mem_a   [DEPTH];
  logic [31:0]      mem_b   [DEPTH];
  logic [2:0]       mem_f   [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [TAG_W-1:0] tag_q;

  logic             push;
  logic             pop;
  logic             capture;
  logic             release_res;
  logic             fifo_nempty;
  logic             f_illegal;

  assign fifo_nempty = (count != '0);
  // Full blocks pushes even when a pop occurs in the same cycle.
  assign in_ready    = !rst && (count != CW'(DEPTH));
  assign push        = in_valid && in_ready;
  assign f_illegal   = (alu_f > 3'b100);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (fifo_nempty) state_next = S_DRIVE;
      S_DRIVE: state_next = S_HOLD;
      S_HOLD:  if (out_ready) state_next = fifo_nempty ? S_DRIVE : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      S_IDLE:  pop = fifo_nempty;
      S_DRIVE: capture = 1'b1;
      S_HOLD: begin
        release_res = out_ready;
        pop         = out_ready && fifo_nempty;
      end
      default: ;
    endcase
  end

  // Storage array carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_f[wr_ptr]   <= in_f;
      mem_tag[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_f     <= '0;
      tag_q     <= '0;
      out_y     <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);

      if (pop) begin
        alu_a <= mem_a[rd_ptr];
        alu_b <= mem_b[rd_ptr];
        alu_f <= mem_f[rd_ptr];
        tag_q <= mem_tag[rd_ptr];
      end

      if (capture) begin
        out_y     <= f_illegal ? 32'h0 : alu_y;
        out_err   <= f_illegal;
        out_tag   <= tag_q;
        out_valid <= 1'b1;
      end else if (release_res) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Directed and scoreboarded self-checking bench for alu_issue_stage.
// Revision : 1.0
// ============================================================================
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_f;
  logic [3:0]  in_tag;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_f;
  logic [31:0] alu_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [3:0]  out_tag;
  logic        out_err;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  tag;
    logic        err;
  } res_t;

  res_t        sb[$];
  res_t        exp_r;
  int          sent;
  int          rcvd;
  int          cyc;
  logic        accepted;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [2:0]  rf;

  alu_issue_stage #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_f(in_f), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .out_err(out_err),
    .count(count)
  );

  always #5 clk = ~clk;

  // Reference ALU; illegal codes produce junk so the stage's zeroing is visible.
  always_comb begin
    case (alu_f)
      3'b000:  alu_y = alu_a & alu_b;
      3'b001:  alu_y = alu_a | alu_b;
      3'b010:  alu_y = ~(alu_a & alu_b);
      3'b011:  alu_y = ~(alu_a | alu_b);
      3'b100:  alu_y = alu_a * alu_b;
      default: alu_y = 32'hDEAD_BEEF;
    endcase
  end

  function automatic logic [31:0] exp_y(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f);
    case (f)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return ~(a & b);
      3'b011:  return ~(a | b);
      3'b100:  return a * b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input logic [3:0] t);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_f     = f;
    in_tag   = t;
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'b000, 4'h0);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_out_y", out_y, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", in_ready, 1'b1);

    // Single AND command, out_ready high
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_00F0, 32'h0000_0FF0, 3'b000, 4'd3);
    tick();
    in_valid = 1'b0;
    chk("s_e0_count", count, 3'd1);
    chk("s_e0_valid", out_valid, 1'b0);
    tick();
    chk("s_e1_alu_a", alu_a, 32'h0000_00F0);
    chk("s_e1_alu_b", alu_b, 32'h0000_0FF0);
    chk("s_e1_valid", out_valid, 1'b0);
    chk("s_e1_count", count, 3'd0);
    tick();
    chk("s_e2_valid", out_valid, 1'b1);
    chk("s_e2_y", out_y, 32'h0000_00F0);
    chk("s_e2_tag", out_tag, 4'd3);
    chk("s_e2_err", out_err, 1'b0);
    tick();
    chk("s_e3_valid", out_valid, 1'b0);
    chk("s_e3_alu_hold", alu_a, 32'h0000_00F0);

    // Illegal code followed by a legal multiply
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b110, 4'd9);
    tick();
    drive(1'b1, 32'd6, 32'd7, 3'b100, 4'd10);
    tick();
    in_valid = 1'b0;
    tick();
    chk("ill_valid", out_valid, 1'b1);
    chk("ill_y", out_y, 32'h0);
    chk("ill_err", out_err, 1'b1);
    chk("ill_tag", out_tag, 4'd9);
    tick();
    chk("ill_gap", out_valid, 1'b0);
    tick();
    chk("mul_valid", out_valid, 1'b1);
    chk("mul_y", out_y, 32'd42);
    chk("mul_err", out_err, 1'b0);
    chk("mul_tag", out_tag, 4'd10);
    tick();
    chk("mul_done", out_valid, 1'b0);
    chk("mul_count", count, 3'd0);

    // Fill under backpressure: tags 0..4, result = (i+1)*256
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(i + 1), 32'h100, 3'b100, 4'(i));
      tick();
    end
    chk("fill_count", count, 3'd4);
    chk("fill_in_ready", in_ready, 1'b0);
    chk("fill_valid", out_valid, 1'b1);
    chk("fill_tag", out_tag, 4'd0);
    chk("fill_y", out_y, 32'h100);
    drive(1'b1, 32'h55, 32'h55, 3'b000, 4'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_count", count, 3'd4);
      chk("stall_tag", out_tag, 4'd0);
      chk("stall_y", out_y, 32'h100);
      chk("stall_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("full_pop_count", count, 3'd3);
    chk("full_pop_valid", out_valid, 1'b0);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("drain_valid", out_valid, 1'b1);
      chk("drain_tag", out_tag, 4'(k));
      chk("drain_y", out_y, 32'((k + 1) * 256));
      tick();
      chk("drain_gap", out_valid, 1'b0);
    end
    chk("drain_count", count, 3'd0);

    // Simultaneous push and pop at count = 2
    out_ready = 1'b0;
    drive(1'b1, 32'd1, 32'd2, 3'b001, 4'd1);
    tick();
    drive(1'b1, 32'd4, 32'd8, 3'b001, 4'd2);
    tick();
    drive(1'b1, 32'h0000_F0F0, 32'h0000_0F0F, 3'b011, 4'd3);
    tick();
    chk("pp_count_pre", count, 3'd2);
    chk("pp_a_tag", out_tag, 4'd1);
    chk("pp_a_y", out_y, 32'd3);
    drive(1'b1, 32'd3, 32'd5, 3'b100, 4'd4);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pp_count_post", count, 3'd2);
    tick();
    chk("pp_b_tag", out_tag, 4'd2);
    chk("pp_b_y", out_y, 32'd12);
    tick();
    tick();
    chk("pp_c_tag", out_tag, 4'd3);
    chk("pp_c_y", out_y, 32'hFFFF_0000);
    tick();
    tick();
    chk("pp_d_tag", out_tag, 4'd4);
    chk("pp_d_y", out_y, 32'd15);
    tick();
    chk("pp_idle", out_valid, 1'b0);

    // Randomised stream through the wrapping pointers
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    in_valid = 1'b0;
    while (rcvd < 10 && cyc < 500) begin
      if (!in_valid && sent < 10 && $urandom_range(0, 2) != 0) begin
        ra = $urandom;
        rb = $urandom;
        rf = 3'($urandom_range(0, 7));
        drive(1'b1, ra, rb, rf, 4'(sent));
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("wrap_count_max", {63'h0, count > 3'd4}, 64'h0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("wrap_unexpected", 64'h1, 64'h0);
        end else begin
          exp_r = sb.pop_front();
          chk("wrap_tag", out_tag, exp_r.tag);
          chk("wrap_y", out_y, exp_r.y);
          chk("wrap_err", out_err, exp_r.err);
        end
        rcvd++;
      end
      accepted = in_valid && in_ready;
      if (accepted) begin
        sb.push_back('{y: exp_y(in_a, in_b, in_f), tag: in_tag, err: (in_f > 3'b100)});
        sent++;
      end
      tick();
      if (accepted) in_valid = 1'b0;
      cyc++;
    end
    chk("wrap_timeout", {63'h0, rcvd == 10}, 64'h1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("wrap_empty", count, 3'd0);

    // Asynchronous reset while holding a result with count = 3
    out_ready = 1'b0;
    for (int i = 1; i < 5; i++) begin
      drive(1'b1, 32'(i), 32'(i), 3'b001, 4'(i));
      tick();
    end
    in_valid = 1'b0;
    chk("mr_pre_valid", out_valid, 1'b1);
    chk("mr_pre_count", count, 3'd3);
    #2 rst = 1'b1;
    #1;
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_count", count, 3'd0);
    chk("mr_in_ready", in_ready, 1'b0);
    chk("mr_alu_a", alu_a, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("mr_rel_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    drive(1'b1, 32'h1234_5678, 32'hFFFF_0000, 3'b000, 4'd5);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mr_e1_valid", out_valid, 1'b0);
    tick();
    chk("mr_e2_valid", out_valid, 1'b1);
    chk("mr_e2_y", out_y, 32'h1234_0000);
    chk("mr_e2_tag", out_tag, 4'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
